// File: rtl/equilibrium_round_referee.sv
`default_nettype none
// ============================================================================
// Module   : equilibrium_round_referee
// Brief    : Referees one balance round: preparation delay, random target,
//            hold-in-window hit detection against a play timeout, score keeping.
// Revision : 1.0 - initial release
// ============================================================================
module equilibrium_round_referee #(
  parameter int PREP_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int HOLD_SAMPLES   = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       abort,
  input  logic       prep_active,
  input  logic       gerar_nova_jogada,
  input  logic       play_active,
  input  logic [1:0] nivel,
  input  logic [7:0] pos_in,
  input  logic       pos_valid,
  output logic       prep_done,
  output logic       ponto_evento,
  output logic       ponto_acerto,
  output logic [7:0] alvo,
  output logic [7:0] score,
  output logic [2:0] db_estado
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_PREP   = 3'd1;
  localparam logic [2:0] c_ST_ARM    = 3'd2;
  localparam logic [2:0] c_ST_PLAY   = 3'd3;
  localparam logic [2:0] c_ST_REPORT = 3'd4;

  localparam int              c_PREP_W    = $clog2(PREP_CYCLES);
  localparam logic [c_PREP_W-1:0] c_PREP_LAST = c_PREP_W'(PREP_CYCLES - 1);
  localparam logic [27:0]     c_PLAY_LAST = 28'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]      c_HOLD_GOAL = 9'(HOLD_SAMPLES);
  localparam logic [7:0]      c_LFSR_SEED = 8'hA5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [c_PREP_W-1:0] r_prep_cnt;
  logic [27:0]         r_play_cnt;
  logic [7:0]          r_hold_cnt;
  logic [7:0]          r_lfsr;
  logic                r_result;

  logic [7:0] w_lfsr_next;
  logic [7:0] w_tol;
  logic [8:0] w_diff;
  logic       w_in_window;
  logic       w_prep_last;
  logic       w_hit;
  logic       w_timeout;

  // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_comb begin
    w_tol = 8'd16;
    case (nivel)
      2'd0:    w_tol = 8'd16;
      2'd1:    w_tol = 8'd8;
      2'd2:    w_tol = 8'd4;
      default: w_tol = 8'd2;
    endcase
  end

  assign w_diff      = (pos_in >= alvo) ? ({1'b0, pos_in} - {1'b0, alvo})
                                        : ({1'b0, alvo} - {1'b0, pos_in});
  assign w_in_window = (w_diff <= {1'b0, w_tol});
  assign w_prep_last = (r_prep_cnt == c_PREP_LAST);
  // Hit is judged on the sample that completes the run, so it can coincide with timeout
  assign w_hit       = pos_valid && w_in_window && (({1'b0, r_hold_cnt} + 9'd1) == c_HOLD_GOAL);
  assign w_timeout   = play_active && (r_play_cnt == c_PLAY_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE:   if (prep_active) w_state_next = c_ST_PREP;
        c_ST_PREP: begin
          if (w_prep_last)       w_state_next = c_ST_ARM;
          else if (!prep_active) w_state_next = c_ST_IDLE;
        end
        c_ST_ARM:    if (gerar_nova_jogada) w_state_next = c_ST_PLAY;
        c_ST_PLAY:   if (w_hit || w_timeout) w_state_next = c_ST_REPORT;
        c_ST_REPORT: w_state_next = c_ST_IDLE;
        default:     w_state_next = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prep_done    = 1'b0;
    ponto_evento = 1'b0;
    ponto_acerto = 1'b0;
    if (!abort) begin
      prep_done    = (r_state == c_ST_PREP) && w_prep_last;
      ponto_evento = (r_state == c_ST_REPORT);
      ponto_acerto = (r_state == c_ST_REPORT) && r_result;
    end
  end

  assign db_estado = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prep_cnt <= '0;
      r_play_cnt <= '0;
      r_hold_cnt <= '0;
      r_lfsr     <= c_LFSR_SEED;
      r_result   <= 1'b0;
      alvo       <= 8'd0;
      score      <= 8'd0;
    end else if (abort) begin
      r_prep_cnt <= '0;
      r_play_cnt <= '0;
      r_hold_cnt <= '0;
      r_result   <= 1'b0;
      score      <= 8'd0;
    end else begin
      case (r_state)
        c_ST_PREP: begin
          if (w_prep_last || !prep_active) r_prep_cnt <= '0;
          else                             r_prep_cnt <= r_prep_cnt + 1'b1;
        end
        c_ST_ARM: begin
          if (gerar_nova_jogada) begin
            r_lfsr     <= w_lfsr_next;
            alvo       <= 8'd64 + {1'b0, w_lfsr_next[6:0]};
            r_play_cnt <= '0;
            r_hold_cnt <= '0;
            r_result   <= 1'b0;
          end
        end
        c_ST_PLAY: begin
          if (play_active) r_play_cnt <= r_play_cnt + 28'd1;
          if (pos_valid) begin
            if (w_in_window) r_hold_cnt <= r_hold_cnt + 8'd1;
            else             r_hold_cnt <= 8'd0;
          end
          if (w_hit)          r_result <= 1'b1;
          else if (w_timeout) r_result <= 1'b0;
        end
        c_ST_REPORT: begin
          if (r_result && (score != 8'hFF)) score <= score + 8'd1;
          r_result   <= 1'b0;
          r_play_cnt <= '0;
          r_hold_cnt <= '0;
        end
        default: begin
          r_prep_cnt <= '0;
          r_play_cnt <= '0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
